tape_conditioner: RTL and testbench
===================================

# tape_conditioner

Conditions the cassette input from the LTC2308 tape ADC interface before it reaches the machine glue's `tape` input. It synchronises the ADC `dout`/`active` pair into `clk_sys`, rejects glitches with a persistence filter, produces one-cycle edge strobes, and measures the rising-edge-to-rising-edge period. It also drives a tape-activity flag for `LED_USER`/`LED_DISK`, which stays lit while edges keep arriving.

## Interface

Parameters:
- `FILTER_LEN`, default 64: consecutive cycles a new level must persist before it is accepted (≥2).
- `ACT_TIMEOUT`, default 1048576: cycles after the last accepted edge before `active` drops (≥1).
- `PERIOD_W`, default 16: width of the period counter and output.
- `INVERT`, default 1: 1 means `tape` = ~filtered level, matching the glue's expected polarity.

Ports:
- `clock` in 1: system clock (`clk_sys`).
- `reset` in 1: synchronous, active-high reset.
- `adc_dout` in 1: comparator level from the tape ADC, CLK_50M domain, asynchronous here.
- `adc_active` in 1: ADC valid flag, asynchronous.
- `tape` out 1: filtered level to the glue, after optional inversion.
- `rise` out 1: one-cycle strobe on an accepted 0→1 transition of the filtered level.
- `fall` out 1: one-cycle strobe on an accepted 1→0 transition.
- `period` out PERIOD_W: cycles between the last two accepted rising edges.
- `period_valid` out 1: one-cycle strobe when `period` updates.
- `active` out 1: tape activity flag.

## Operation

- Synchroniser: two flops each on `adc_dout` and `adc_active`. The raw level is `s_dout & s_active`, so an inactive ADC reads as 0.
- Filter: `filt` register plus a counter `fcnt` with ceil(log2 FILTER_LEN) bits.
  - If raw equals `filt`, `fcnt` goes to 0.
  - Otherwise `fcnt` increments. When it would reach FILTER_LEN, `filt` toggles and `fcnt` goes to 0.
  - Any return to the `filt` level restarts the count.
- Edges: `filt_d` is `filt` delayed one cycle.
  - `rise = filt & ~filt_d`.
  - `fall = ~filt & filt_d`.
  - Never both in one cycle.
- Period: state `have_edge` (0/1), counter `pcnt`.
  - While `have_edge` is 1, `pcnt` increments every cycle and saturates at 2^PERIOD_W−1.
  - On `rise`: `pcnt` loads 1 and `have_edge` is set.
  - On `rise` with `have_edge` already 1: `period` also loads `pcnt` and `period_valid` pulses.
  - The first rise after reset gives no `period_valid`.
  - Saturated values are reported as-is.
- Activity: down-counter `acnt`.
  - Loads ACT_TIMEOUT on `rise` or `fall`; otherwise decrements to 0 and holds there.
  - `active = (acnt != 0)`.
  - A reload wins over decrement in the same cycle.
- Output: `tape = filt ^ INVERT`.

## Timing

Reset values:
- All synchroniser flops, `filt`, `filt_d`, `fcnt`, `pcnt`, `have_edge` and `acnt` are 0.
- `period` is 0.
- Outputs after reset: `tape` = INVERT; `rise`, `fall`, `period_valid` and `active` are 0.

Latency:
- A raw change sampled at edge 0 reaches the synchroniser output at edge 2.
- `filt` toggles at edge 1+FILTER_LEN+1, i.e. FILTER_LEN+2 edges after the change.
- `tape` and `rise`/`fall` change in the cycle immediately after that edge.
- `period`, `period_valid` and `active` update on the clock edge that ends the `rise` cycle and are visible the following cycle.

Boundary conditions:
- Pulse width: raw pulses of FILTER_LEN−1 cycles or shorter are fully rejected; FILTER_LEN cycles is the minimum accepted width.
- Edge spacing: accepted edges are therefore at least FILTER_LEN cycles apart, and `rise` and `fall` cannot collide.
- Reset mid-operation: `reset` asserted in any cycle clears all state at that edge. No strobe is issued in the cycle after reset, even if `filt` was 1 before.
- `adc_active` drop: treated as a level-0 input. It goes through the filter like any other level, so a drop shorter than FILTER_LEN is ignored.

## Test plan

All scenarios use FILTER_LEN=4, ACT_TIMEOUT=100, PERIOD_W=16, INVERT=1.

1. Reset: assert `reset` with random inputs → next cycle `tape`=1, `period`=0, all strobes 0, `active`=0.
2. Glitch rejection: `adc_active`=1, `adc_dout` high for 3 cycles → no change on any output. High for 4 cycles → `tape` falls and `rise` pulses exactly 6 edges after the first high sample.
3. Square wave, period 40, 50% duty, for 5 periods:
   - First `rise`: no `period_valid`.
   - Each later `rise`: `period_valid` pulses with `period`=40.
   - `active` stays 1 throughout.
4. Activity timeout: stop the input after the last `fall` → `active` remains 1 for exactly 100 cycles, then 0. A new edge at cycle 99 re-extends it.
5. Saturation: wait 70000 cycles between two accepted rises → `period`=65535, `period_valid`=1.
6. Reset mid-pulse: `filt`=1 with `pcnt`=20, assert `reset` → no `fall` pulse, `have_edge` cleared. The next two rises 30 cycles apart yield one `period_valid` with `period`=30.

Source files
------------

// File: rtl/tape_conditioner_if.sv
// Bundle of tape ADC inputs and conditioned outputs shared by tape_conditioner and its users.
// The slave modport is the conditioner's view; the master modport is the ADC/glue side.
interface tape_conditioner_if #(
    parameter int unsigned PERIOD_W = 16
) ();
    logic                adc_dout;
    logic                adc_active;
    logic                tape;
    logic                rise;
    logic                fall;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                active;

    modport master (
        output adc_dout, adc_active,
        input  tape, rise, fall, period, period_valid, active
    );

    modport slave (
        input  adc_dout, adc_active,
        output tape, rise, fall, period, period_valid, active
    );
endinterface

// File: rtl/tape_conditioner.sv
// Cassette input conditioner: synchronises the ADC comparator level, applies a persistence
// filter, emits edge strobes, measures rise-to-rise period and keeps a tape-activity flag.
module tape_conditioner #(
    parameter int unsigned FILTER_LEN  = 64,
    parameter int unsigned ACT_TIMEOUT = 1048576,
    parameter int unsigned PERIOD_W    = 16,
    parameter bit          INVERT      = 1'b1
) (
    input logic               clock,
    input logic               reset,
    tape_conditioner_if.slave bus
);
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN);
    localparam int unsigned ACNT_W = $clog2(ACT_TIMEOUT + 1);

    localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [ACNT_W-1:0]   ACNT_LOAD = ACNT_W'(ACT_TIMEOUT);
    localparam logic [PERIOD_W-1:0] PCNT_MAX  = '1;

    logic [1:0]          sync_dout_q, sync_dout_d;
    logic [1:0]          sync_act_q, sync_act_d;
    logic                filt_q, filt_d;
    logic                filt_dly_q, filt_dly_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                have_edge_q, have_edge_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic [ACNT_W-1:0]   acnt_q, acnt_d;

    logic raw;
    logic rise;
    logic fall;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        sync_dout_d    = {sync_dout_q[0], bus.adc_dout};
        sync_act_d     = {sync_act_q[0], bus.adc_active};
        filt_d         = filt_q;
        fcnt_d         = '0;
        filt_dly_d     = filt_q;
        have_edge_d    = have_edge_q;
        pcnt_d         = pcnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        acnt_d         = acnt_q;

        // An inactive ADC reads as level 0 and is filtered like any other level.
        raw = sync_dout_q[1] & sync_act_q[1];

        if (raw != filt_q) begin
            if (fcnt_q == FCNT_LAST) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        rise = filt_q & ~filt_dly_q;
        fall = ~filt_q & filt_dly_q;

        if (rise) begin
            pcnt_d      = {{(PERIOD_W-1){1'b0}}, 1'b1};
            have_edge_d = 1'b1;
            if (have_edge_q) begin
                period_d       = pcnt_q;
                period_valid_d = 1'b1;
            end
        end else if (have_edge_q && pcnt_q != PCNT_MAX) begin
            pcnt_d = pcnt_q + 1'b1;
        end

        // Reload has priority so activity is extended even when the counter is about to expire.
        if (rise || fall) begin
            acnt_d = ACNT_LOAD;
        end else if (acnt_q != '0) begin
            acnt_d = acnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the
        // pre-edge values regardless of statement order.
        if (reset) begin
            sync_dout_q    <= '0;
            sync_act_q     <= '0;
            filt_q         <= 1'b0;
            filt_dly_q     <= 1'b0;
            fcnt_q         <= '0;
            have_edge_q    <= 1'b0;
            pcnt_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            acnt_q         <= '0;
        end else begin
            sync_dout_q    <= sync_dout_d;
            sync_act_q     <= sync_act_d;
            filt_q         <= filt_d;
            filt_dly_q     <= filt_dly_d;
            fcnt_q         <= fcnt_d;
            have_edge_q    <= have_edge_d;
            pcnt_q         <= pcnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            acnt_q         <= acnt_d;
        end
    end

    assign bus.tape         = filt_q ^ INVERT;
    assign bus.rise         = rise;
    assign bus.fall         = fall;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.active       = (acnt_q != '0);
endmodule

// File: tb/tb_tape_conditioner.sv
// Directed bench for tape_conditioner with FILTER_LEN=4, ACT_TIMEOUT=100, PERIOD_W=16, INVERT=1.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_tape_conditioner;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    tape_conditioner_if #(.PERIOD_W(16)) bus ();

    tape_conditioner #(
        .FILTER_LEN (4),
        .ACT_TIMEOUT(100),
        .PERIOD_W   (16),
        .INVERT     (1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.adc_dout   = 1'b0;
        bus.adc_active = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_fall(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = bus.fall;
        end
    endtask

    task automatic wait_rise(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = bus.rise;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            bus.adc_dout   = 1'($urandom);
            bus.adc_active = 1'($urandom);
            reset = 1'b1;
            step();
            checks++;
            if ({bus.tape, bus.rise, bus.fall, bus.period_valid, bus.active} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_outputs: got tape/rise/fall/pv/active=%b expected 10000",
                         {bus.tape, bus.rise, bus.fall, bus.period_valid, bus.active});
            end
            checks++;
            if (bus.period !== 16'd0) begin
                errors++;
                $display("FAIL reset_period: got %0d expected 0", bus.period);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_glitch();
        logic [2:0] exp_v;
        do_reset();
        bus.adc_dout = 1'b1;
        for (int i = 1; i <= 3; i++) step();
        bus.adc_dout = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if ({bus.tape, bus.rise, bus.fall, bus.active} !== 4'b1000) begin
                errors++;
                $display("FAIL glitch_3cyc step %0d: got tape/rise/fall/active=%b expected 1000",
                         i, {bus.tape, bus.rise, bus.fall, bus.active});
            end
        end
        // Four-cycle pulse: accepted rise 6 edges after the first high sample, fall 4 later.
        bus.adc_dout = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 4) bus.adc_dout = 1'b0;
            exp_v = {(i < 6 || i >= 10), (i == 6), (i == 10)};
            checks++;
            if ({bus.tape, bus.rise, bus.fall} !== exp_v) begin
                errors++;
                $display("FAIL glitch_4cyc step %0d: got tape/rise/fall=%b expected %b",
                         i, {bus.tape, bus.rise, bus.fall}, exp_v);
            end
        end
        checks++;
        if (bus.active !== 1'b1 || bus.period_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_after: got active=%b pv=%b expected active=1 pv=0",
                     bus.active, bus.period_valid);
        end
    endtask

    task automatic test_square();
        int  nrise = 0;
        int  nvalid = 0;
        bit  prev_rise = 1'b0;
        do_reset();
        for (int c = 0; c < 220; c++) begin
            bus.adc_dout = (c < 200) && ((c % 40) < 20);
            step();
            if (bus.period_valid) begin
                nvalid++;
                checks++;
                if (!prev_rise || nrise < 2 || bus.period !== 16'd40) begin
                    errors++;
                    $display("FAIL square_valid cycle %0d: got period=%0d after_rise=%b rises=%0d expected period=40 after a non-first rise",
                             c, bus.period, prev_rise, nrise);
                end
            end
            if (nrise > 0) begin
                checks++;
                if (bus.active !== 1'b1) begin
                    errors++;
                    $display("FAIL square_active cycle %0d: got %b expected 1", c, bus.active);
                end
            end
            if (bus.rise) nrise++;
            prev_rise = bus.rise;
        end
        checks++;
        if (nrise != 5 || nvalid != 4) begin
            errors++;
            $display("FAIL square_counts: got rises=%0d valids=%0d expected rises=5 valids=4",
                     nrise, nvalid);
        end
    endtask

    task automatic test_activity();
        bit found;
        do_reset();
        bus.adc_dout = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus.adc_dout = 1'b0;
        wait_fall(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL activity_fall_timeout: got no fall strobe expected one within 40 cycles");
            return;
        end
        for (int i = 1; i <= 101; i++) begin
            step();
            checks++;
            if (bus.active !== (i <= 100)) begin
                errors++;
                $display("FAIL activity_timeout cycle %0d: got %b expected %b", i, bus.active, (i <= 100));
            end
        end
    endtask

    task automatic test_activity_extend();
        bit found;
        do_reset();
        bus.adc_dout = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus.adc_dout = 1'b0;
        wait_fall(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL extend_fall_timeout: got no fall strobe expected one within 40 cycles");
            return;
        end
        for (int i = 1; i <= 200; i++) begin
            step();
            if (i == 93) bus.adc_dout = 1'b1;
            if (i == 99) begin
                checks++;
                if (bus.rise !== 1'b1 || bus.active !== 1'b1) begin
                    errors++;
                    $display("FAIL extend_rise cycle 99: got rise=%b active=%b expected 1 1", bus.rise, bus.active);
                end
            end
            if (i >= 100) begin
                checks++;
                if (bus.active !== (i < 200)) begin
                    errors++;
                    $display("FAIL extend_active cycle %0d: got %b expected %b", i, bus.active, (i < 200));
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit found;
        do_reset();
        bus.adc_dout = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus.adc_dout = 1'b0;
        repeat (70000) step();
        bus.adc_dout = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = bus.period_valid;
        end
        checks++;
        if (!found || bus.period !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation: got pv_seen=%b period=%0d expected pv_seen=1 period=65535",
                     found, bus.period);
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit found;
        int nvalid = 0;
        int nrise = 0;
        do_reset();
        bus.adc_dout = 1'b1;
        wait_rise(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_rise_timeout: got no rise strobe expected one within 40 cycles");
            return;
        end
        repeat (20) step();
        reset = 1'b1;
        bus.adc_dout = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({bus.tape, bus.rise, bus.fall, bus.period_valid, bus.active} !== 5'b10000 || bus.period !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got tape/rise/fall/pv/active=%b period=%0d expected 10000 period=0",
                     {bus.tape, bus.rise, bus.fall, bus.period_valid, bus.active}, bus.period);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.rise !== 1'b0 || bus.fall !== 1'b0) begin
                errors++;
                $display("FAIL midreset_strobe cycle %0d: got rise=%b fall=%b expected 0 0", i, bus.rise, bus.fall);
            end
        end
        for (int c = 0; c < 60; c++) begin
            bus.adc_dout = (c < 10) || (c >= 30);
            step();
            if (bus.rise) nrise++;
            if (bus.period_valid) begin
                nvalid++;
                checks++;
                if (bus.period !== 16'd30) begin
                    errors++;
                    $display("FAIL midreset_period: got %0d expected 30", bus.period);
                end
            end
        end
        checks++;
        if (nrise != 2 || nvalid != 1) begin
            errors++;
            $display("FAIL midreset_counts: got rises=%0d valids=%0d expected rises=2 valids=1", nrise, nvalid);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.adc_dout   = 1'b0;
        bus.adc_active = 1'b0;
        step();
        test_reset();
        test_glitch();
        test_square();
        test_activity();
        test_activity_extend();
        test_saturation();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
